// File: rtl/redtin_capture_sequencer.sv
// RedTin capture sequencer: ring-buffer pre/post-trigger capture and ordered readout.
// Ports: clk, reset_n (sync, active low); arm/abort control pulses;
//   din probe bus; trig_value/trig_mask/trig_edge trigger setup;
//   buf_we/buf_waddr/buf_wdata RAM write port;
//   buf_raddr/buf_rdata RAM read port (1-cycle latency);
//   rd_start starts readout; out_data/out_valid/out_ready stream to the host;
//   done marks a full window; status shows the state.
module redtin_capture_sequencer #(
    parameter int WIDTH       = 128,
    parameter int ADDR_BITS   = 9,
    parameter int PRE_SAMPLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     din,
    input  logic [WIDTH-1:0]     trig_value,
    input  logic [WIDTH-1:0]     trig_mask,
    input  logic [WIDTH-1:0]     trig_edge,
    output logic                 buf_we,
    output logic [ADDR_BITS-1:0] buf_waddr,
    output logic [WIDTH-1:0]     buf_wdata,
    output logic [ADDR_BITS-1:0] buf_raddr,
    input  logic [WIDTH-1:0]     buf_rdata,
    input  logic                 rd_start,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 done,
    output logic [2:0]           status
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] PRE_LAST  = ADDR_BITS'(PRE_SAMPLES - 1);
    localparam logic [ADDR_BITS-1:0] POST_LAST = ADDR_BITS'(DEPTH - PRE_SAMPLES - 2);
    localparam logic [ADDR_BITS-1:0] PRE_OFS   = ADDR_BITS'(PRE_SAMPLES);
    localparam logic [ADDR_BITS-1:0] RD_LAST   = ADDR_BITS'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRETRIG    = 3'd1,
        S_WAIT_TRIG  = 3'd2,
        S_POST       = 3'd3,
        S_DONE       = 3'd4,
        S_RD_ISSUE   = 3'd5,
        S_RD_WAIT    = 3'd6,
        S_RD_PRESENT = 3'd7
    } state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] wptr;
    logic [ADDR_BITS-1:0] cnt;
    logic [ADDR_BITS-1:0] trig_addr;
    logic [ADDR_BITS-1:0] rd_cnt;
    logic [WIDTH-1:0]     prev;

    logic                 capturing;
    logic                 hit;
    logic [WIDTH-1:0]     lvl_bits;
    logic [WIDTH-1:0]     edge_bits;
    logic [WIDTH-1:0]     miss;

    // A masked bit misses if it is a level bit that differs from
    // trig_value, or an edge bit that did not go 0 -> 1.
    always_comb begin
        capturing = (state == S_PRETRIG) || (state == S_WAIT_TRIG) ||
                    (state == S_POST);
        lvl_bits  = trig_mask & ~trig_edge;
        edge_bits = trig_mask & trig_edge;
        miss      = (lvl_bits & (din ^ trig_value)) |
                    (edge_bits & ~(din & ~prev));
        hit       = (miss == '0);
    end

    assign status = state;

    // buf_raddr doubles as the read pointer so the address is already
    // on the RAM during RD_ISSUE and data is ready in RD_WAIT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            buf_we    <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
            buf_raddr <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            wptr      <= '0;
            cnt       <= '0;
            trig_addr <= '0;
            rd_cnt    <= '0;
            prev      <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            buf_we    <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            buf_we <= capturing;
            if (capturing) begin
                buf_wdata <= din;
                buf_waddr <= wptr;
                wptr      <= wptr + 1'b1;
                prev      <= din;
            end
            unique case (state)
                S_IDLE: begin
                    if (arm) begin
                        wptr  <= '0;
                        cnt   <= '0;
                        state <= S_PRETRIG;
                    end
                end
                S_PRETRIG: begin
                    if (cnt == PRE_LAST) begin
                        cnt   <= '0;
                        state <= S_WAIT_TRIG;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_TRIG: begin
                    if (hit) begin
                        trig_addr <= wptr;
                        cnt       <= '0;
                        state     <= S_POST;
                    end
                end
                S_POST: begin
                    if (cnt == POST_LAST) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (arm) begin
                        done  <= 1'b0;
                        wptr  <= '0;
                        cnt   <= '0;
                        state <= S_PRETRIG;
                    end else if (rd_start) begin
                        buf_raddr <= trig_addr - PRE_OFS;
                        rd_cnt    <= '0;
                        state     <= S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: begin
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    out_data  <= buf_rdata;
                    out_valid <= 1'b1;
                    state     <= S_RD_PRESENT;
                end
                S_RD_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        buf_raddr <= buf_raddr + 1'b1;
                        rd_cnt    <= rd_cnt + 1'b1;
                        if (rd_cnt == RD_LAST) begin
                            done  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_RD_ISSUE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_redtin_capture_sequencer.sv
// Scoreboard bench for redtin_capture_sequencer with a behavioural sample RAM.
// Probe bus is a free-running count; expected windows are queued at arm time.
module tb_redtin_capture_sequencer;

    localparam int W     = 8;
    localparam int AB    = 4;
    localparam int PRE   = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          rd_start = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  trig_value = '0;
    logic [W-1:0]  trig_mask = '0;
    logic [W-1:0]  trig_edge = '0;
    logic          buf_we;
    logic [AB-1:0] buf_waddr;
    logic [W-1:0]  buf_wdata;
    logic [AB-1:0] buf_raddr;
    logic [W-1:0]  buf_rdata = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          done;
    logic [2:0]    status;

    logic [W-1:0]  mem [DEPTH];

    int            n_chk = 0;
    int            n_fail = 0;
    int            hs = 0;
    int            rdy_mode = 0;
    int            cyc = 0;
    logic [W-1:0]  exp_q [$];

    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic [W-1:0]  pd = '0;

    redtin_capture_sequencer #(
        .WIDTH(W),
        .ADDR_BITS(AB),
        .PRE_SAMPLES(PRE)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .arm(arm),
        .abort(abort),
        .din(din),
        .trig_value(trig_value),
        .trig_mask(trig_mask),
        .trig_edge(trig_edge),
        .buf_we(buf_we),
        .buf_waddr(buf_waddr),
        .buf_wdata(buf_wdata),
        .buf_raddr(buf_raddr),
        .buf_rdata(buf_rdata),
        .rd_start(rd_start),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done(done),
        .status(status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (buf_we) mem[buf_waddr] <= buf_wdata;
        buf_rdata <= mem[buf_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound,
                              input string tag);
        int k = 0;
        while (status !== s && k < bound) begin
            step;
            k++;
        end
        chk(tag, {29'd0, status}, {29'd0, s});
    endtask

    task automatic arm_at(input logic [W-1:0] a);
        int k = 0;
        while (din !== a && k < 600) begin
            step;
            k++;
        end
        chk("arm_sync", {24'd0, din}, {24'd0, a});
        arm = 1'b1;
        step;
        arm = 1'b0;
        chk("arm_pretrig", {29'd0, status}, 32'd1);
        chk("arm_we_low", {31'd0, buf_we}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_status"}, {29'd0, status}, 32'd0);
        chk({tag, "_we"}, {31'd0, buf_we}, 32'd0);
        chk({tag, "_waddr"}, {28'd0, buf_waddr}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, buf_wdata}, 32'd0);
        chk({tag, "_raddr"}, {28'd0, buf_raddr}, 32'd0);
        chk({tag, "_odata"}, {24'd0, out_data}, 32'd0);
        chk({tag, "_ovalid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_capture(input logic [W-1:0] a, input logic [W-1:0] m,
                               input logic [W-1:0] v, input logic [W-1:0] e,
                               input logic [W-1:0] first, input int mode);
        logic [W-1:0] a1;
        logic [W-1:0] w;
        trig_mask  = m;
        trig_value = v;
        trig_edge  = e;
        rdy_mode   = mode;
        hs         = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w = first + W'(i);
            exp_q.push_back(w);
        end
        a1 = a + 8'd1;
        arm_at(a);
        step;
        chk("wr_we", {31'd0, buf_we}, 32'd1);
        chk("wr_addr0", {28'd0, buf_waddr}, 32'd0);
        chk("wr_data0", {24'd0, buf_wdata}, {24'd0, a1});
        wait_state(3'd4, 400, "reach_done");
        chk("done_set", {31'd0, done}, 32'd1);
        rd_start = 1'b1;
        step;
        rd_start = 1'b0;
        wait_state(3'd0, 400, "rd_to_idle");
        chk("hs_count", hs, 32'd16);
        chk("q_empty", exp_q.size(), 32'd0);
        chk("done_clr", {31'd0, done}, 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            din = din + 8'd1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (out_valid && pv && !pr)
                chk("hold_data", {24'd0, out_data}, {24'd0, pd});
            if (out_valid && out_ready) begin
                hs++;
                if (exp_q.size() == 0)
                    chk("extra_word", {24'd0, out_data}, 32'hffff_ffff);
                else
                    chk("word", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) step;
        reset_n = 1'b1;
        check_all_zero("rst");
        repeat (20) begin
            step;
            chk("idle", {26'd0, status, buf_we, done, out_valid}, 32'd0);
        end

        run_capture(8'h10, 8'hff, 8'h30, 8'h00, 8'h2c, 0);
        run_capture(8'h41, 8'h01, 8'h00, 8'h01, 8'h43, 0);
        run_capture(8'h80, 8'hff, 8'ha8, 8'h00, 8'ha4, 0);
        run_capture(8'hc0, 8'h00, 8'h00, 8'h00, 8'hc1, 1);

        trig_mask = 8'h00;
        trig_edge = 8'h00;
        rdy_mode  = 0;
        arm_at(8'h00);
        wait_state(3'd4, 100, "ab_done");
        arm      = 1'b1;
        rd_start = 1'b1;
        step;
        arm      = 1'b0;
        rd_start = 1'b0;
        chk("arm_wins", {29'd0, status}, 32'd1);
        chk("arm_wins_done", {31'd0, done}, 32'd0);
        wait_state(3'd3, 100, "ab_post");
        abort = 1'b1;
        step;
        abort = 1'b0;
        chk("abort_status", {29'd0, status}, 32'd0);
        chk("abort_we", {31'd0, buf_we}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);

        rdy_mode = 2;
        arm_at(8'h20);
        wait_state(3'd4, 100, "mr_done");
        rd_start = 1'b1;
        step;
        rd_start = 1'b0;
        wait_state(3'd7, 20, "mr_present");
        chk("mr_first", {24'd0, out_data}, 32'h21);
        step;
        chk("mr_stall", {30'd0, status[2], out_valid}, 32'd3);
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
        check_all_zero("mrst");
        exp_q.delete();

        run_capture(8'h60, 8'hff, 8'h70, 8'h00, 8'h6c, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/redtin_capture_sequencer.md
Name: redtin_capture_sequencer

Overview:
Capture controller for the RedTin logic analyzer core. It sequences the sample buffer RAM through the arm, pre-trigger fill, trigger wait, post-trigger capture and readout phases. It evaluates a masked value/edge trigger on the probe bus. It then streams the captured window to the host-side transport (UART framer) in chronological order over a valid/ready handshake.

Parameters:
WIDTH, 128, probe bus / sample word width in bits
ADDR_BITS, 9, log2 of buffer depth; DEPTH = 2**ADDR_BITS
PRE_SAMPLES, 64, samples retained before the trigger sample; legal range 1..DEPTH-2

Ports:
clk  in  1  capture and control clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
arm  in  1  single-cycle pulse: start a capture
abort  in  1  single-cycle pulse: return to IDLE from any state
din  in  WIDTH  probe samples, one per clk
trig_value  in  WIDTH  required bit values for level-match bits
trig_mask  in  WIDTH  1 = bit participates in the trigger
trig_edge  in  WIDTH  1 = masked bit must rise (previous 0, current 1) rather than match trig_value
buf_we  out  1  sample RAM write enable
buf_waddr  out  ADDR_BITS  sample RAM write address
buf_wdata  out  WIDTH  sample RAM write data (registered din)
buf_raddr  out  ADDR_BITS  sample RAM read address; RAM has 1-cycle read latency
buf_rdata  in  WIDTH  sample RAM read data
rd_start  in  1  pulse in DONE: begin readout
out_data  out  WIDTH  readout word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
done  out  1  capture complete, buffer holds a full window
status  out  3  current state encoding, driven to board LEDs

Behaviour:
- Reset (reset_n=0 at clk edge): state IDLE; buf_we, buf_waddr, buf_wdata, buf_raddr, out_data, out_valid, done all 0; internal counters and previous-sample register 0.
- State encoding (status): IDLE=0, PRETRIG=1, WAIT_TRIG=2, POST=3, DONE=4, RD_ISSUE=5, RD_WAIT=6, RD_PRESENT=7.
- Write path: in PRETRIG, WAIT_TRIG and POST, din is registered. On the next cycle buf_we=1, buf_wdata is the registered sample, and buf_waddr is the write pointer. The pointer increments per write and wraps DEPTH-1 -> 0. buf_we=0 in all other states.
- IDLE: on arm, clear the write pointer and the fill count, then go to PRETRIG. arm is also honoured in DONE, where it clears done and re-arms. arm is ignored in every other state.
- PRETRIG: capture every cycle. Trigger is not evaluated. After exactly PRE_SAMPLES samples, go to WAIT_TRIG.
- WAIT_TRIG: capture every cycle, overwriting ring-wise. The trigger hits on a sample when every masked bit passes: level bits satisfy din==trig_value; edge bits satisfy prev==0 and din==1. trig_mask=0 means an immediate hit on the first WAIT_TRIG sample. The previous-sample register updates on every capture cycle.
- On a hit, latch trig_addr = the address that sample is written to, and go to POST.
- POST: capture exactly DEPTH-PRE_SAMPLES-1 further samples, then go to DONE with done=1. The window is then: start_addr = trig_addr-PRE_SAMPLES mod DEPTH; trigger sample at offset PRE_SAMPLES.
- Readout: rd_start in DONE sets the read pointer to start_addr and enters RD_ISSUE. done stays 1 until readout completes.
  - RD_ISSUE drives buf_raddr, then goes to RD_WAIT.
  - RD_WAIT registers buf_rdata into out_data, sets out_valid=1, and goes to RD_PRESENT.
  - RD_PRESENT holds out_data and out_valid stable until out_ready. On the out_valid&out_ready cycle, out_valid drops next cycle and the read pointer increments mod DEPTH.
  - After DEPTH words, go to IDLE with done=0. Otherwise go back to RD_ISSUE.
- abort: has priority over all other inputs. Next state is IDLE; buf_we=0, out_valid=0 and done=0 from the next cycle. Buffer contents are undefined.
- arm and rd_start together in DONE: arm wins.
- reset_n low mid-capture or mid-readout behaves identically to power-on reset.

Test Plan:
(All with WIDTH=8, ADDR_BITS=4, PRE_SAMPLES=4, din = free-running 8-bit count.)
- Reset then idle: hold reset_n=0 for 3 cycles, release, no arm -> status=0, buf_we=0, done=0, out_valid=0 for 20 cycles.
- Level trigger: trig_mask=FF, trig_value=0x30, arm at din=0x10 -> done asserts; readout of 16 words is 0x2C..0x3B in order; word 4 is 0x30.
- Edge trigger: trig_mask=0x01, trig_edge=0x01 -> trigger on the first odd din after WAIT_TRIG; that word appears at readout index 4 with the preceding 4 words consecutive.
- Ring wrap: trigger 40 cycles after arm -> start_addr wraps correctly; readout still strictly consecutive, 16 words.
- Backpressure: out_ready asserted every 3rd cycle -> out_data stable while out_valid && !out_ready; no word lost or duplicated; IDLE after 16 handshakes.
- Abort and mid-operation reset: abort in POST -> status=0 and buf_we=0 next cycle. reset_n low during RD_PRESENT -> all outputs 0. Re-arm afterwards yields a correct capture.
